// File: rtl/arm_pkg.sv
// Shared types and constants for the operand-forwarding / hazard-detection slice.
// Holds the select encoding, the shadow-stage record layouts and the bubble constants.
package arm_pkg;

    localparam int REG_IDX_W = 4;

    // Operand source for the EXE stage; 2'b11 is reserved and never produced.
    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_ALU = 2'b01,
        SEL_WB  = 2'b10
    } sel_src_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic                 wb;
        logic                 mr;
    } ex_stage_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic                 wb;
    } mem_stage_t;

    localparam ex_stage_t BUBBLE = '{
        dest: {REG_IDX_W{1'b0}},
        wb:   1'b0,
        mr:   1'b0
    };

    localparam mem_stage_t MEM_BUBBLE = '{
        dest: {REG_IDX_W{1'b0}},
        wb:   1'b0
    };

    function automatic logic reg_hit(
        input logic                 wb,
        input logic [REG_IDX_W-1:0] dest,
        input logic [REG_IDX_W-1:0] src
    );
        reg_hit = wb & (dest == src);
    endfunction

endpackage : arm_pkg

// File: rtl/fwd_sel_calc.sv
// Per-source match logic: decides the stall contribution and the forwarding
// select for one decode-stage operand against the EXE and MEM shadow stages.
module fwd_sel_calc
    import arm_pkg::*;
(
    input  logic                 i_forward_en,
    input  logic                 i_live,
    input  logic [REG_IDX_W-1:0] i_src,
    input  ex_stage_t            i_ex,
    input  mem_stage_t           i_mem,
    output logic                 o_hazard,
    output sel_src_e             o_sel
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = i_live & reg_hit(i_ex.wb,  i_ex.dest,  i_src);
    assign w_mem_match = i_live & reg_hit(i_mem.wb, i_mem.dest, i_src);

    // Stall request: only load-use when forwarding, any pending write otherwise.
    always_comb begin
        o_hazard = 1'b0;
        if (i_forward_en) begin
            o_hazard = w_ex_match & i_ex.mr;
        end else begin
            o_hazard = w_ex_match | w_mem_match;
        end
    end

    // Operand select; the younger producer in EXE wins over the one in MEM.
    always_comb begin
        o_sel = SEL_RF;
        if (!i_forward_en) begin
            o_sel = SEL_RF;
        end else if (w_ex_match) begin
            o_sel = SEL_ALU;
        end else if (w_mem_match) begin
            o_sel = SEL_WB;
        end else begin
            o_sel = SEL_RF;
        end
    end

endmodule : fwd_sel_calc

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks the EXE/MEM destinations in shadow registers,
// raises a combinational stall and registers the EXE-stage operand selects.
module fwd_hazard_unit
    import arm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forward_en,
    input  logic                 ID_valid,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 src1_used,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] ID_Dest,
    input  logic                 ID_WB_EN,
    input  logic                 ID_MEM_R_EN,
    input  logic                 flush,
    output logic [1:0]           Sel_src1,
    output logic [1:0]           Sel_src2,
    output logic                 hazard
);

    ex_stage_t  r_ex;
    mem_stage_t r_mem;
    sel_src_e   r_sel1;
    sel_src_e   r_sel2;

    ex_stage_t  w_ex_next;
    logic       w_live1;
    logic       w_live2;
    logic       w_haz1;
    logic       w_haz2;
    logic       w_hazard;
    logic       w_squash;
    sel_src_e   w_sel1;
    sel_src_e   w_sel2;

    assign w_live1 = ID_valid & src1_used;
    assign w_live2 = ID_valid & two_src;

    fwd_sel_calc u_calc_src1 (
        .i_forward_en (forward_en),
        .i_live       (w_live1),
        .i_src        (src1),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .o_hazard     (w_haz1),
        .o_sel        (w_sel1)
    );

    fwd_sel_calc u_calc_src2 (
        .i_forward_en (forward_en),
        .i_live       (w_live2),
        .i_src        (src2),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .o_hazard     (w_haz2),
        .o_sel        (w_sel2)
    );

    // Record entering EXE; an invalid decode slot must not look like a writer.
    always_comb begin
        w_ex_next.dest = ID_Dest;
        w_ex_next.wb   = ID_WB_EN & ID_valid;
        w_ex_next.mr   = ID_MEM_R_EN & ID_valid;
    end

    // A flushed decode instruction never stalls the front end.
    always_comb begin
        w_hazard = 1'b0;
        if (flush) begin
            w_hazard = 1'b0;
        end else begin
            w_hazard = w_haz1 | w_haz2;
        end
    end

    assign w_squash = flush | w_hazard;
    assign hazard   = w_hazard;

    // Shadow pipeline and select registers; reset beats flush, flush/stall insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex   <= BUBBLE;
            r_mem  <= MEM_BUBBLE;
            r_sel1 <= SEL_RF;
            r_sel2 <= SEL_RF;
        end else if (w_squash) begin
            r_ex   <= BUBBLE;
            r_mem  <= '{dest: r_ex.dest, wb: r_ex.wb};
            r_sel1 <= SEL_RF;
            r_sel2 <= SEL_RF;
        end else begin
            r_ex   <= w_ex_next;
            r_mem  <= '{dest: r_ex.dest, wb: r_ex.wb};
            r_sel1 <= w_sel1;
            r_sel2 <= w_sel2;
        end
    end

    assign Sel_src1 = r_sel1;
    assign Sel_src2 = r_sel2;

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table followed by
// randomized traffic checked against an in-flight-instruction reference model.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst;
    logic       forward_en;
    logic       ID_valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       src1_used;
    logic       two_src;
    logic [3:0] ID_Dest;
    logic       ID_WB_EN;
    logic       ID_MEM_R_EN;
    logic       flush;
    logic [1:0] Sel_src1;
    logic [1:0] Sel_src2;
    logic       hazard;

    int n_vec = 0;
    int n_err = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .forward_en  (forward_en),
        .ID_valid    (ID_valid),
        .src1        (src1),
        .src2        (src2),
        .src1_used   (src1_used),
        .two_src     (two_src),
        .ID_Dest     (ID_Dest),
        .ID_WB_EN    (ID_WB_EN),
        .ID_MEM_R_EN (ID_MEM_R_EN),
        .flush       (flush),
        .Sel_src1    (Sel_src1),
        .Sel_src2    (Sel_src2),
        .hazard      (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fe;
        logic       v;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic [3:0] d;
        logic       wb;
        logic       mr;
        logic       fl;
        logic       exp_h;
        logic [1:0] exp_s1;
        logic [1:0] exp_s2;
    } vec_t;

    // In-flight instruction as seen by the reference model (index 0 = youngest).
    typedef struct {
        logic [3:0] dest;
        bit         wr;
        bit         ld;
    } inst_t;

    vec_t  vecs[$];
    inst_t inflight[$];
    logic [1:0] m_sel1;
    logic [1:0] m_sel2;

    function automatic vec_t mk(
        input logic rst_i, input logic fe, input logic v,
        input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2,
        input logic [3:0] d, input logic wb, input logic mr, input logic fl,
        input logic eh, input logic [1:0] e1, input logic [1:0] e2
    );
        vec_t t;
        t.rst = rst_i; t.fe = fe; t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2;
        t.d = d; t.wb = wb; t.mr = mr; t.fl = fl;
        t.exp_h = eh; t.exp_s1 = e1; t.exp_s2 = e2;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step=%0d got=%0b expected=%0b", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; forward_en = t.fe; ID_valid = t.v;
        src1 = t.s1; src1_used = t.u1; src2 = t.s2; two_src = t.u2;
        ID_Dest = t.d; ID_WB_EN = t.wb; ID_MEM_R_EN = t.mr; flush = t.fl;
    endtask

    // Youngest in-flight producer of register r: 0 = EXE, 1 = MEM, -1 = none.
    function automatic int producer_age(input logic [3:0] r);
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].wr && inflight[i].dest == r) return i;
        end
        return -1;
    endfunction

    function automatic bit src_stalls(input bit fe, input int age);
        if (fe) return (age == 0) && inflight[0].ld;
        return age >= 0;
    endfunction

    function automatic logic [1:0] src_sel(input bit fe, input int age);
        if (fe && age == 0) return 2'd1;
        if (fe && age == 1) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        inst_t b;
        b.dest = 4'd0; b.wr = 1'b0; b.ld = 1'b0;
        inflight = {b, b};
        m_sel1 = 2'd0;
        m_sel2 = 2'd0;
    endtask

    initial begin
        vec_t  t;
        inst_t ni;
        int    a1;
        int    a2;
        bit    mh;
        logic [1:0] n1;
        logic [1:0] n2;

        // Directed sequence: hazard is combinational for the row's inputs,
        // the selects shown are those registered from the previous row.
        vecs.push_back(mk(1'b1,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd1,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd1,1'b1, 4'd0,1'b0, 4'd5,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd1,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd2,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd2,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd2,1'b1, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd2,1'b1, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd3,1'b1,1'b1,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd3,1'b1, 4'd0,1'b0, 4'd6,1'b1,1'b0,1'b0, 1'b1,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd3,1'b1, 4'd0,1'b0, 4'd6,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd2,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd4,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b1, 4'd4,1'b1, 4'd0,1'b0, 4'd7,1'b1,1'b0,1'b0, 1'b1,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b1, 4'd4,1'b1, 4'd0,1'b0, 4'd7,1'b1,1'b0,1'b0, 1'b1,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b1, 4'd4,1'b1, 4'd0,1'b0, 4'd7,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd3,1'b1,1'b1,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd3,1'b1, 4'd0,1'b0, 4'd8,1'b1,1'b0,1'b1, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd8,1'b1, 4'd3,1'b1, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd9,1'b1,1'b1,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd9,1'b1, 4'd0,1'b0, 4'd10,1'b1,1'b0,1'b0, 1'b1,2'd0,2'd0));
        vecs.push_back(mk(1'b1,1'b1,1'b1, 4'd9,1'b1, 4'd0,1'b0, 4'd10,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd9,1'b1, 4'd0,1'b0, 4'd10,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd15,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd15,1'b1, 4'd15,1'b1, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd1,2'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b1, 4'd0,1'b0, 4'd0,1'b0, 4'd11,1'b1,1'b1,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd11,1'b1, 4'd11,1'b1, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));

        drive(mk(1'b1,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("dir_hazard", i, {1'b0, hazard}, {1'b0, vecs[i].exp_h});
            chk("dir_sel1",   i, Sel_src1, vecs[i].exp_s1);
            chk("dir_sel2",   i, Sel_src2, vecs[i].exp_s2);
            @(posedge clk);
            #1;
        end

        // Random phase: resynchronise the model with one reset edge first.
        drive(mk(1'b1,1'b1,1'b0, 4'd0,1'b0, 4'd0,1'b0, 4'd0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd0));
        @(posedge clk);
        #1;
        model_reset();
        forward_en = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            t.rst = ($urandom_range(0, 49) == 0);
            t.fe  = ($urandom_range(0, 19) == 0) ? ~forward_en : forward_en;
            t.v   = ($urandom_range(0, 3) != 0);
            t.s1  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            t.s2  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            t.d   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            t.u1  = ($urandom_range(0, 3) != 0);
            t.u2  = ($urandom_range(0, 1) != 0);
            t.wb  = ($urandom_range(0, 3) != 0);
            t.mr  = t.wb && ($urandom_range(0, 2) == 0);
            t.fl  = ($urandom_range(0, 9) == 0);
            drive(t);

            a1 = (t.v && t.u1) ? producer_age(t.s1) : -1;
            a2 = (t.v && t.u2) ? producer_age(t.s2) : -1;
            mh = !t.fl && (src_stalls(t.fe, a1) || src_stalls(t.fe, a2));
            n1 = src_sel(t.fe, a1);
            n2 = src_sel(t.fe, a2);

            @(negedge clk);
            chk("rnd_hazard", c, {1'b0, hazard}, {1'b0, logic'(mh)});
            chk("rnd_sel1",   c, Sel_src1, m_sel1);
            chk("rnd_sel2",   c, Sel_src2, m_sel2);
            @(posedge clk);
            #1;

            if (t.rst) begin
                model_reset();
            end else begin
                if (t.fl || mh) begin
                    ni.dest = 4'd0; ni.wr = 1'b0; ni.ld = 1'b0;
                    m_sel1 = 2'd0;
                    m_sel2 = 2'd0;
                end else begin
                    ni.dest = t.d; ni.wr = t.wb && t.v; ni.ld = t.mr && t.v;
                    m_sel1 = n1;
                    m_sel2 = n2;
                end
                inflight.push_front(ni);
                void'(inflight.pop_back());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fwd_hazard_unit
